rn_wr_injector: RTL and testbench
=================================

# rn_wr_injector

Requester-node write injector: the initiating end of the NoC write protocol whose target end is the SN write tracker. Accepts AXI-style AW/W bursts from a local master and injects them into the NoC as an AW flit followed by W flits tagged with WID, SrcID and TgtID. Keeps a table of outstanding write IDs, matches returning B responses from the NoC against it, frees the matching entry, and returns B to the master.

## Interface
- RN_WRTRACKER_NUM, 8, outstanding-write tracker entries (power of two, 2..32)
- SRC_ID, 2'd0, this node's ID, driven on SrcID
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- AWID_M  in  11  master write ID
- AWLEN_M  in  8  burst length minus 1
- AWTGT_M  in  2  destination SN ID
- AWVALID_M / AWREADY_M  in / out  1  master AW handshake
- WDATA_M  in  64  write data
- WSTRB_M  in  8  byte strobes
- WLAST_M  in  1  last beat marker
- WVALID_M / WREADY_M  in / out  1  master W handshake
- BID_M  out  11  response ID to master
- BVALID_M / BREADY_M  out / in  1  master B handshake
- AWID_NOC  out  11; AWLEN_NOC  out  8; AWVALID_NOC / AWREADY_NOC  out / in  1
- SrcID  out  2  constant SRC_ID
- TgtID  out  2  destination of the current AW/W burst
- WID_NOC  out  11; WDATA_NOC  out  64; WSTRB_NOC  out  8; WVALID_NOC / WREADY_NOC  out / in  1
- BID_NOC  in  11; BVALID_NOC / BREADY_NOC  in / out  1
- outstanding  out  $clog2(RN_WRTRACKER_NUM)+1  count of valid tracker entries
- protocol_err  out  1  sticky error flag

## Operation
- FSM states: IDLE, AW_SEND, W_SEND.
- IDLE: AWREADY_M = free entry exists (and no ID conflict, see Configuration). On AW handshake:
  - capture ID, LEN and TGT;
  - allocate the lowest-index free tracker entry (valid=1, id=AWID_M);
  - move to AW_SEND.
- AW_SEND: AWVALID_NOC=1 with the captured ID/LEN. TgtID = captured TGT. On AWREADY_NOC, clear the beat counter and move to W_SEND.
- W_SEND: combinational pass-through.
  - WVALID_NOC=WVALID_M, WREADY_M=WREADY_NOC.
  - WID_NOC = captured ID; data and strobes forwarded unchanged.
  - Each beat handshake increments the 8-bit beat counter.
  - Beat where counter==LEN: return to IDLE.
  - WLAST_M must be asserted on exactly that beat. A mismatch in either direction sets protocol_err; the burst still ends on the counted length.
- WREADY_M=0 outside W_SEND. W beats arriving early are back-pressured.
- B path: single-entry output register.
  - BREADY_NOC = !BVALID_M | BREADY_M.
  - On a B_NOC handshake, CAM BID_NOC against valid entries; the lowest-index hit is freed and BID is loaded into the register (BVALID_M=1).
  - Miss: response dropped, protocol_err set, no entry freed.
- Allocate and free in the same cycle always target distinct entries. `outstanding` nets the two (+1, −1, or 0).

## Timing
- Reset values:
  - all VALID outputs, AWREADY_M, WREADY_M, BREADY_NOC: 0 during rst;
  - FSM state: IDLE;
  - trackers: invalid;
  - outstanding: 0; protocol_err: 0;
  - data and ID outputs: 0.
- AW accepted in cycle N → AWVALID_NOC high in cycle N+1. Minimum 1 cycle.
- W beats: zero added latency and no bubbles within a burst. A new AW is accepted at the earliest in the cycle after the last W beat.
- B: accepted in cycle N → BVALID_M in cycle N+1. Full throughput of 1 response/cycle while BREADY_M=1.
- Tracker full: AWREADY_M=0 until a B frees an entry. The freed entry is allocatable in the cycle after the freeing B handshake.
- AWVALID_NOC and WVALID_NOC hold stable until their ready is seen.
- rst mid-burst: everything returns to reset values next cycle. The partial burst is abandoned.

## Configuration
- RN_WR_ID_ORDER_EN, defined:
  - AWREADY_M is also gated low while any valid entry holds AWID_M;
  - at most one outstanding write per ID;
  - responses therefore match uniquely.
- RN_WR_ID_ORDER_EN, undefined:
  - same-ID writes may be outstanding concurrently;
  - B frees the lowest-index matching entry.

## Test plan
- Single burst: AWID=0x12, LEN=3, TGT=2, four W beats with WLAST on beat 4, AWREADY_NOC tied 1 → AWVALID_NOC for 1 cycle with TgtID=2, four W_NOC beats with WID=0x12. BID_NOC=0x12 → BVALID_M next cycle with BID_M=0x12, outstanding 1→0.
- Fill: 8 single-beat writes with IDs 0..7 and no B → 9th AWVALID_M stalls (AWREADY_M=0). B with ID 3 → 9th AW accepted in the following cycle, into entry 3.
- Back-pressure: toggle WREADY_NOC and AWREADY_NOC randomly → no beat lost or duplicated, counter ends at LEN+1 beats. BREADY_M=0 with two B arriving → BREADY_NOC drops after the first.
- Errors: WLAST on beat 2 of a LEN=3 burst → protocol_err=1, burst still ends after 4 beats. B with unknown ID 0x7FF → dropped, protocol_err stays 1.
- Same ID twice (ID 5): with RN_WR_ID_ORDER_EN → second AW stalls until B(5). Without it → both accepted, outstanding=2, two B(5) drain to 0.
- Reset asserted during W_SEND beat 2 → all outputs 0 next cycle. A new burst after rst completes normally.

Source files
------------

// File: rtl/rn_wr_injector_if.sv
// Master-side AW/W/B and NoC-side AW/W/B channels of the requester-node write injector.
// slave = injector view, master = local master + NoC view (used by the bench).
interface rn_wr_injector_if;
  logic [10:0] AWID_M;
  logic [7:0]  AWLEN_M;
  logic [1:0]  AWTGT_M;
  logic        AWVALID_M;
  logic        AWREADY_M;
  logic [63:0] WDATA_M;
  logic [7:0]  WSTRB_M;
  logic        WLAST_M;
  logic        WVALID_M;
  logic        WREADY_M;
  logic [10:0] BID_M;
  logic        BVALID_M;
  logic        BREADY_M;
  logic [10:0] AWID_NOC;
  logic [7:0]  AWLEN_NOC;
  logic        AWVALID_NOC;
  logic        AWREADY_NOC;
  logic [1:0]  SrcID;
  logic [1:0]  TgtID;
  logic [10:0] WID_NOC;
  logic [63:0] WDATA_NOC;
  logic [7:0]  WSTRB_NOC;
  logic        WVALID_NOC;
  logic        WREADY_NOC;
  logic [10:0] BID_NOC;
  logic        BVALID_NOC;
  logic        BREADY_NOC;

  modport slave (
    input  AWID_M, AWLEN_M, AWTGT_M, AWVALID_M, output AWREADY_M,
    input  WDATA_M, WSTRB_M, WLAST_M, WVALID_M, output WREADY_M,
    output BID_M, BVALID_M, input BREADY_M,
    output AWID_NOC, AWLEN_NOC, AWVALID_NOC, input AWREADY_NOC,
    output SrcID, TgtID,
    output WID_NOC, WDATA_NOC, WSTRB_NOC, WVALID_NOC, input WREADY_NOC,
    input  BID_NOC, BVALID_NOC, output BREADY_NOC
  );

  modport master (
    output AWID_M, AWLEN_M, AWTGT_M, AWVALID_M, input AWREADY_M,
    output WDATA_M, WSTRB_M, WLAST_M, WVALID_M, input WREADY_M,
    input  BID_M, BVALID_M, output BREADY_M,
    input  AWID_NOC, AWLEN_NOC, AWVALID_NOC, output AWREADY_NOC,
    input  SrcID, TgtID,
    input  WID_NOC, WDATA_NOC, WSTRB_NOC, WVALID_NOC, output WREADY_NOC,
    output BID_NOC, BVALID_NOC, input BREADY_NOC
  );
endinterface

// File: rtl/rn_wr_injector.sv
// Requester-node write injector: AW/W bursts into NoC flits, outstanding-ID tracker, B return.
// Define RN_WR_ID_ORDER_EN to allow at most one outstanding write per ID.
module rn_wr_injector #(
  parameter int         RN_WRTRACKER_NUM = 8,
  parameter logic [1:0] SRC_ID           = 2'd0
) (
  input  logic clk,
  input  logic rst,
  rn_wr_injector_if.slave bus,
  output logic [$clog2(RN_WRTRACKER_NUM):0] outstanding,
  output logic protocol_err
);
  localparam int IW = $clog2(RN_WRTRACKER_NUM);
  localparam int CW = IW + 1;

  typedef enum logic [1:0] {IDLE, AW_SEND, W_SEND} state_t;

  state_t      state;
  logic [10:0] cap_id;
  logic [7:0]  cap_len;
  logic [1:0]  cap_tgt;
  logic [7:0]  beat_cnt;
  logic [RN_WRTRACKER_NUM-1:0] trk_valid;
  logic [10:0] trk_id [RN_WRTRACKER_NUM];
  logic        b_valid;
  logic [10:0] b_id;

  logic          free_any, hit_any, id_conflict;
  logic [IW-1:0] free_idx, hit_idx;
  logic          in_w, aw_hs, w_hs, b_hs, last_beat;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    free_any    = 1'b0;
    free_idx    = '0;
    hit_any     = 1'b0;
    hit_idx     = '0;
    id_conflict = 1'b0;
    // Descending scan so the lowest index is the one left standing.
    for (int i = RN_WRTRACKER_NUM - 1; i >= 0; i--) begin
      if (!trk_valid[i]) begin
        free_any = 1'b1;
        free_idx = IW'(i);
      end
      if (trk_valid[i] && trk_id[i] == bus.BID_NOC) begin
        hit_any = 1'b1;
        hit_idx = IW'(i);
      end
    end
`ifdef RN_WR_ID_ORDER_EN
    for (int i = 0; i < RN_WRTRACKER_NUM; i++)
      if (trk_valid[i] && trk_id[i] == bus.AWID_M) id_conflict = 1'b1;
`endif
  end

  assign in_w      = !rst && state == W_SEND;
  assign last_beat = beat_cnt == cap_len;

  assign bus.AWREADY_M   = !rst && state == IDLE && free_any && !id_conflict;
  assign bus.AWVALID_NOC = !rst && state == AW_SEND;
  assign bus.AWID_NOC    = cap_id;
  assign bus.AWLEN_NOC   = cap_len;
  assign bus.SrcID       = SRC_ID;
  assign bus.TgtID       = cap_tgt;

  // W is a pure pass-through while bursting; data is zeroed outside a burst.
  assign bus.WVALID_NOC = in_w && bus.WVALID_M;
  assign bus.WREADY_M   = in_w && bus.WREADY_NOC;
  assign bus.WID_NOC    = cap_id;
  assign bus.WDATA_NOC  = in_w ? bus.WDATA_M : '0;
  assign bus.WSTRB_NOC  = in_w ? bus.WSTRB_M : '0;

  assign bus.BID_M      = b_id;
  assign bus.BVALID_M   = b_valid;
  assign bus.BREADY_NOC = !rst && (!b_valid || bus.BREADY_M);

  assign aw_hs = bus.AWVALID_M && bus.AWREADY_M;
  assign w_hs  = bus.WVALID_NOC && bus.WREADY_NOC;
  assign b_hs  = bus.BVALID_NOC && bus.BREADY_NOC;

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cap_id       <= '0;
      cap_len      <= '0;
      cap_tgt      <= '0;
      beat_cnt     <= '0;
      trk_valid    <= '0;
      b_valid      <= 1'b0;
      b_id         <= '0;
      outstanding  <= '0;
      protocol_err <= 1'b0;
    end else begin
      case (state)
        IDLE: if (aw_hs) begin
          cap_id  <= bus.AWID_M;
          cap_len <= bus.AWLEN_M;
          cap_tgt <= bus.AWTGT_M;
          state   <= AW_SEND;
        end
        AW_SEND: if (bus.AWREADY_NOC) begin
          beat_cnt <= '0;
          state    <= W_SEND;
        end
        W_SEND: if (w_hs) begin
          beat_cnt <= beat_cnt + 8'd1;
          // The counted length wins; WLAST disagreement only flags an error.
          if (bus.WLAST_M != last_beat) protocol_err <= 1'b1;
          if (last_beat) state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      // Allocation picks a free entry and freeing picks a valid one, so they never collide.
      if (aw_hs)            trk_valid[free_idx] <= 1'b1;
      if (b_hs && hit_any)  trk_valid[hit_idx]  <= 1'b0;
      if (b_hs && !hit_any) protocol_err        <= 1'b1;

      if (b_valid && bus.BREADY_M) b_valid <= 1'b0;
      if (b_hs && hit_any) begin
        b_valid <= 1'b1;
        b_id    <= bus.BID_NOC;
      end

      outstanding <= outstanding + CW'(aw_hs) - CW'(b_hs && hit_any);
    end
  end

  // NOTE: tracker IDs are storage qualified by trk_valid, so they are deliberately not reset.
  always_ff @(posedge clk) begin
    if (aw_hs) trk_id[free_idx] <= bus.AWID_M;
  end
endmodule

// File: tb/tb_rn_wr_injector.sv
// Self-checking bench for rn_wr_injector: directed steps with AW/W/B scoreboards.
// Expectations for the same-ID case follow RN_WR_ID_ORDER_EN.
module tb_rn_wr_injector;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] outstanding;
  logic protocol_err;

  rn_wr_injector_if bus ();

  rn_wr_injector #(.RN_WRTRACKER_NUM(8), .SRC_ID(2'd1)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave),
    .outstanding(outstanding), .protocol_err(protocol_err)
  );

  always #5 clk = ~clk;

  typedef struct {logic [10:0] id; logic [7:0] len; logic [1:0] tgt;} aw_t;
  typedef struct {logic [10:0] id; logic [63:0] data; logic [7:0] strb;} w_t;

  aw_t         aw_q[$];
  w_t          w_q[$];
  logic [10:0] b_q[$];

  int errors = 0;
  int checks = 0;
  int w_beats = 0;
  int aw_valid_cycles = 0;
  bit rand_bp = 1'b0;
  logic aw_pend = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic fail(input string tag);
    checks++;
    errors++;
    $error("FAIL %s (timeout or unexpected event)", tag);
  endtask

  // Monitors sample at the falling edge, half a cycle away from the active edge.
  always @(negedge clk) begin
    aw_t e;
    if (rst) aw_pend = 1'b0;
    else begin
      if (aw_pend) check("aw_noc_hold", bus.AWVALID_NOC, 1'b1);
      if (bus.AWVALID_NOC) aw_valid_cycles++;
      if (bus.AWVALID_NOC && bus.AWREADY_NOC) begin
        if (aw_q.size() == 0) fail("aw_noc_unexpected");
        else begin
          e = aw_q.pop_front();
          check("aw_noc_id", bus.AWID_NOC, e.id);
          check("aw_noc_len", bus.AWLEN_NOC, e.len);
          check("aw_noc_tgt", bus.TgtID, e.tgt);
        end
      end
      aw_pend = bus.AWVALID_NOC && !bus.AWREADY_NOC;
    end
  end

  always @(negedge clk) begin
    w_t e;
    if (!rst && bus.WVALID_NOC && bus.WREADY_NOC) begin
      w_beats++;
      if (w_q.size() == 0) fail("w_noc_unexpected");
      else begin
        e = w_q.pop_front();
        check("w_noc_id", bus.WID_NOC, e.id);
        check("w_noc_data", bus.WDATA_NOC, e.data);
        check("w_noc_strb", bus.WSTRB_NOC, e.strb);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && bus.BVALID_M && bus.BREADY_M) begin
      if (b_q.size() == 0) fail("b_m_unexpected");
      else check("b_m_id", bus.BID_M, b_q.pop_front());
    end
  end

  always @(posedge clk) begin
    #1;
    if (rand_bp) begin
      bus.AWREADY_NOC = 1'($urandom_range(0, 1));
      bus.WREADY_NOC  = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // All tasks start and end one time unit after a rising edge.
  task automatic aw(input logic [10:0] id, input logic [7:0] len, input logic [1:0] tgt);
    int n = 0;
    bus.AWID_M = id; bus.AWLEN_M = len; bus.AWTGT_M = tgt; bus.AWVALID_M = 1'b1;
    aw_q.push_back('{id, len, tgt});
    @(negedge clk);
    while (!bus.AWREADY_M && n < 200) begin n++; @(negedge clk); end
    if (n >= 200) fail("aw_accept_wait");
    @(posedge clk); #1;
    bus.AWVALID_M = 1'b0;
  endtask

  task automatic w_burst(input logic [10:0] id, input int nbeats, input int last_at);
    for (int k = 0; k < nbeats; k++) begin
      int n = 0;
      bus.WDATA_M  = {$urandom, $urandom};
      bus.WSTRB_M  = 8'($urandom);
      bus.WLAST_M  = (k == last_at);
      bus.WVALID_M = 1'b1;
      w_q.push_back('{id, bus.WDATA_M, bus.WSTRB_M});
      @(negedge clk);
      while (!bus.WREADY_M && n < 200) begin n++; @(negedge clk); end
      if (n >= 200) fail("w_beat_wait");
      @(posedge clk); #1;
    end
    bus.WVALID_M = 1'b0;
    bus.WLAST_M  = 1'b0;
  endtask

  task automatic b_send(input logic [10:0] id, input bit hit);
    int n = 0;
    bus.BID_NOC = id; bus.BVALID_NOC = 1'b1;
    if (hit) b_q.push_back(id);
    @(negedge clk);
    while (!bus.BREADY_NOC && n < 200) begin n++; @(negedge clk); end
    if (n >= 200) fail("b_noc_wait");
    @(posedge clk); #1;
    bus.BVALID_NOC = 1'b0;
    @(negedge clk);
    check("b_m_valid_next", bus.BVALID_M, hit);
    if (hit) check("b_m_id_next", bus.BID_M, id);
    @(posedge clk); #1;
  endtask

  initial begin
    int base;
    int drain [8] = '{0, 1, 2, 4, 5, 6, 7, 9};
    bus.AWID_M = '0; bus.AWLEN_M = '0; bus.AWTGT_M = '0; bus.AWVALID_M = 1'b1;
    bus.WDATA_M = 64'hDEAD_BEEF_0123_4567; bus.WSTRB_M = 8'hFF; bus.WLAST_M = 1'b0;
    bus.WVALID_M = 1'b1; bus.BREADY_M = 1'b1;
    bus.AWREADY_NOC = 1'b1; bus.WREADY_NOC = 1'b1;
    bus.BID_NOC = '0; bus.BVALID_NOC = 1'b1;

    // Reset state, with inputs deliberately active.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_awready_m", bus.AWREADY_M, 1'b0);
    check("rst_wready_m", bus.WREADY_M, 1'b0);
    check("rst_bready_noc", bus.BREADY_NOC, 1'b0);
    check("rst_awvalid_noc", bus.AWVALID_NOC, 1'b0);
    check("rst_wvalid_noc", bus.WVALID_NOC, 1'b0);
    check("rst_bvalid_m", bus.BVALID_M, 1'b0);
    check("rst_wdata_noc", bus.WDATA_NOC, 64'd0);
    check("rst_awid_noc", bus.AWID_NOC, 11'd0);
    check("rst_bid_m", bus.BID_M, 11'd0);
    check("rst_outstanding", outstanding, 4'd0);
    check("rst_protocol_err", protocol_err, 1'b0);
    @(posedge clk); #1;
    bus.AWVALID_M = 1'b0; bus.WVALID_M = 1'b0; bus.BVALID_NOC = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    check("idle_awready_m", bus.AWREADY_M, 1'b1);
    check("src_id", bus.SrcID, 2'd1);
    @(posedge clk); #1;

    // Single burst.
    aw_valid_cycles = 0;
    base = w_beats;
    aw(11'h12, 8'd3, 2'd2);
    @(negedge clk);
    check("aw_latency_valid", bus.AWVALID_NOC, 1'b1);
    check("aw_latency_tgt", bus.TgtID, 2'd2);
    check("aw_wready_m_early", bus.WREADY_M, 1'b0);
    @(posedge clk); #1;
    w_burst(11'h12, 4, 3);
    check("single_aw_cycles", aw_valid_cycles, 1);
    check("single_beats", w_beats - base, 4);
    check("single_outstanding", outstanding, 4'd1);
    b_send(11'h12, 1'b1);
    check("single_drained", outstanding, 4'd0);

    // Fill the tracker, then free entry 3 and let the stalled AW in.
    for (int i = 0; i < 8; i++) begin
      aw(11'(i), 8'd0, 2'(i));
      w_burst(11'(i), 1, 0);
    end
    check("fill_outstanding", outstanding, 4'd8);
    bus.AWID_M = 11'd9; bus.AWLEN_M = 8'd0; bus.AWTGT_M = 2'd3; bus.AWVALID_M = 1'b1;
    aw_q.push_back('{11'd9, 8'd0, 2'd3});
    repeat (3) begin
      @(negedge clk);
      check("full_awready_m", bus.AWREADY_M, 1'b0);
      @(posedge clk); #1;
    end
    bus.BID_NOC = 11'd3; bus.BVALID_NOC = 1'b1;
    b_q.push_back(11'd3);
    @(negedge clk);
    check("free_bready_noc", bus.BREADY_NOC, 1'b1);
    check("free_same_cycle_awready", bus.AWREADY_M, 1'b0);
    @(posedge clk); #1;
    bus.BVALID_NOC = 1'b0;
    @(negedge clk);
    check("freed_awready_m", bus.AWREADY_M, 1'b1);
    @(posedge clk); #1;
    bus.AWVALID_M = 1'b0;
    w_burst(11'd9, 1, 0);
    check("refill_outstanding", outstanding, 4'd8);
    foreach (drain[i]) b_send(11'(drain[i]), 1'b1);
    check("fill_drained", outstanding, 4'd0);

    // Random NoC back-pressure.
    base = w_beats;
    rand_bp = 1'b1;
    aw(11'h33, 8'd7, 2'd1);
    w_burst(11'h33, 8, 7);
    aw(11'h34, 8'd2, 2'd3);
    w_burst(11'h34, 3, 2);
    rand_bp = 1'b0;
    @(posedge clk); #1;
    bus.AWREADY_NOC = 1'b1; bus.WREADY_NOC = 1'b1;
    check("bp_beats", w_beats - base, 11);
    check("bp_w_q_empty", w_q.size(), 0);

    // B back-pressure: the output register fills and BREADY_NOC drops.
    bus.BREADY_M = 1'b0;
    bus.BID_NOC = 11'h33; bus.BVALID_NOC = 1'b1;
    b_q.push_back(11'h33);
    @(negedge clk);
    check("bbp_first_ready", bus.BREADY_NOC, 1'b1);
    @(posedge clk); #1;
    bus.BID_NOC = 11'h34;
    b_q.push_back(11'h34);
    @(negedge clk);
    check("bbp_bready_drop", bus.BREADY_NOC, 1'b0);
    check("bbp_bvalid_m", bus.BVALID_M, 1'b1);
    @(posedge clk); #1;
    @(negedge clk);
    check("bbp_hold_ready", bus.BREADY_NOC, 1'b0);
    check("bbp_outstanding", outstanding, 4'd1);
    @(posedge clk); #1;
    bus.BREADY_M = 1'b1;
    @(negedge clk);
    check("bbp_release_ready", bus.BREADY_NOC, 1'b1);
    @(posedge clk); #1;
    bus.BVALID_NOC = 1'b0;
    @(negedge clk);
    check("bbp_drained", outstanding, 4'd0);
    @(posedge clk); #1;

    // WLAST early on a LEN=3 burst, then an unknown B ID.
    check("err_clear_before", protocol_err, 1'b0);
    base = w_beats;
    aw(11'h40, 8'd3, 2'd0);
    w_burst(11'h40, 4, 1);
    @(negedge clk);
    check("err_wlast_flag", protocol_err, 1'b1);
    check("err_burst_beats", w_beats - base, 4);
    check("err_back_to_idle", bus.AWREADY_M, 1'b1);
    @(posedge clk); #1;
    b_send(11'h40, 1'b1);
    b_send(11'h7FF, 1'b0);
    check("miss_outstanding", outstanding, 4'd0);
    check("miss_err_sticky", protocol_err, 1'b1);

    // Same ID twice.
    aw(11'd5, 8'd0, 2'd1);
    w_burst(11'd5, 1, 0);
`ifdef RN_WR_ID_ORDER_EN
    bus.AWID_M = 11'd5; bus.AWLEN_M = 8'd0; bus.AWTGT_M = 2'd2; bus.AWVALID_M = 1'b1;
    aw_q.push_back('{11'd5, 8'd0, 2'd2});
    repeat (3) begin
      @(negedge clk);
      check("same_id_stall", bus.AWREADY_M, 1'b0);
      @(posedge clk); #1;
    end
    b_send(11'd5, 1'b1);
    bus.AWVALID_M = 1'b0;
    @(negedge clk);
    check("same_id_accepted", outstanding, 4'd1);
    @(posedge clk); #1;
    w_burst(11'd5, 1, 0);
    b_send(11'd5, 1'b1);
`else
    aw(11'd5, 8'd0, 2'd2);
    w_burst(11'd5, 1, 0);
    check("same_id_both", outstanding, 4'd2);
    b_send(11'd5, 1'b1);
    check("same_id_one_left", outstanding, 4'd1);
    b_send(11'd5, 1'b1);
`endif
    check("same_id_drained", outstanding, 4'd0);

    // Reset during the second W beat.
    aw(11'h21, 8'd3, 2'd2);
    begin
      int n = 0;
      bus.WDATA_M = {$urandom, $urandom}; bus.WSTRB_M = 8'hA5;
      bus.WLAST_M = 1'b0; bus.WVALID_M = 1'b1;
      w_q.push_back('{11'h21, bus.WDATA_M, bus.WSTRB_M});
      @(negedge clk);
      while (!bus.WREADY_M && n < 200) begin n++; @(negedge clk); end
      if (n >= 200) fail("rst_beat1_wait");
      @(posedge clk); #1;
    end
    bus.WDATA_M = 64'h1111_2222_3333_4444;
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_wvalid_noc", bus.WVALID_NOC, 1'b0);
    check("mid_rst_wready_m", bus.WREADY_M, 1'b0);
    check("mid_rst_wdata_noc", bus.WDATA_NOC, 64'd0);
    check("mid_rst_awready_m", bus.AWREADY_M, 1'b0);
    check("mid_rst_bready_noc", bus.BREADY_NOC, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    bus.WVALID_M = 1'b0;
    @(negedge clk);
    check("post_rst_outstanding", outstanding, 4'd0);
    check("post_rst_protocol_err", protocol_err, 1'b0);
    check("post_rst_awid_noc", bus.AWID_NOC, 11'd0);
    check("post_rst_tgtid", bus.TgtID, 2'd0);
    check("post_rst_wvalid_noc", bus.WVALID_NOC, 1'b0);
    check("post_rst_awready_m", bus.AWREADY_M, 1'b1);
    @(posedge clk); #1;
    base = w_beats;
    aw(11'h22, 8'd1, 2'd3);
    w_burst(11'h22, 2, 1);
    check("post_rst_beats", w_beats - base, 2);
    b_send(11'h22, 1'b1);
    check("post_rst_drained", outstanding, 4'd0);
    check("post_rst_no_err", protocol_err, 1'b0);

    repeat (2) @(posedge clk);
    check("aw_q_empty", aw_q.size(), 0);
    check("w_q_empty", w_q.size(), 0);
    check("b_q_empty", b_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
